// File: rtl/tlb_walker_pkg.sv
// tlb_walker_pkg: walker states, PTE bit indices, error-code positions and helpers (TLB_WALKER_PDE_CACHE_EN selects the PDE cache)
package tlb_walker_pkg;
  typedef enum logic [2:0] {IDLE, PDE_RD, PDE_WB, PTE_RD, PTE_WB, FILL, FAULT} state_t;
  localparam int P   = 0;
  localparam int RW  = 1;
  localparam int US  = 2;
  localparam int PWT = 3;
  localparam int PCD = 4;
  localparam int A   = 5;
  localparam int D   = 6;
  localparam int EC_P = 0;
  localparam int EC_W = 1;
  localparam int EC_U = 2;
  localparam logic [31:0] A_MASK = 32'h0000_0020;
  localparam logic [31:0] D_MASK = 32'h0000_0040;
  function automatic logic [31:0] entry_addr(input logic [19:0] base, input logic [9:0] idx);
    return {base, idx, 2'b00};
  endfunction
  function automatic logic perm_fail(input logic [31:0] pde, input logic [31:0] pte,
                                     input logic rw, input logic su, input logic wp);
    logic crw, csu;
    crw = pde[RW] & pte[RW];
    csu = pde[US] & pte[US];
    return (su & ~csu) | (rw & ~crw & (su | wp));
  endfunction
  function automatic logic [2:0] fault_code(input logic su, input logic rw, input logic p);
    logic [2:0] c;
    c = 3'b000;
    c[EC_U] = su;
    c[EC_W] = rw;
    c[EC_P] = p;
    return c;
  endfunction
endpackage

// File: rtl/tlb_walker_pde_cache.sv
// tlb_walker_pde_cache: one-entry PDE cache keyed by lin[31:22], used when TLB_WALKER_PDE_CACHE_EN is defined
module tlb_walker_pde_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr,
  input  logic [9:0]  tag,
  input  logic [31:0] wr_pde,
  output logic        hit,
  output logic [31:0] pde
);
  logic       valid;
  logic [9:0] tag_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      tag_q <= '0;
      pde   <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
      tag_q <= tag;
      pde   <= wr_pde;
    end
  assign hit = valid && tag_q == tag;
endmodule

// File: rtl/tlb_walker.sv
// tlb_walker: two-level i386 page walker with A/D write-back and TLB fill; TLB_WALKER_PDE_CACHE_EN adds a PDE cache
module tlb_walker
  import tlb_walker_pkg::*;
#(
  parameter bit WB_AD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cr3,
  input  logic        cr0_wp,
  input  logic        walk_req,
  input  logic [31:0] walk_linear,
  input  logic        walk_rw,
  input  logic        walk_su,
  output logic        walk_done,
  output logic        walk_fault,
  output logic [2:0]  walk_fault_code,
  output logic        walk_retry,
  input  logic        tlbflushsingle_do,
  input  logic        tlbflushall_do,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        tlbregs_write_do,
  output logic [31:0] tlbregs_write_linear,
  output logic [31:0] tlbregs_write_physical,
  output logic        tlbregs_write_pwt,
  output logic        tlbregs_write_pcd,
  output logic        tlbregs_write_combined_rw,
  output logic        tlbregs_write_combined_su
);
  state_t      state;
  logic        stale;
  logic [31:0] pde, pte, lin;
  logic        flush;
  logic        hit;
  logic [31:0] cached_pde;
  logic        unused_ok;
  assign flush = tlbflushall_do | tlbflushsingle_do;
  assign unused_ok = ^cr3[11:0];
`ifdef TLB_WALKER_PDE_CACHE_EN
  logic acked, fault_now;
  assign acked = mem_req & mem_ack;
  assign fault_now = acked & ((state == PDE_RD & ~mem_rdata[P]) |
                              (state == PTE_RD & (~mem_rdata[P] | perm_fail(pde, mem_rdata, walk_rw, walk_su, cr0_wp))));
  tlb_walker_pde_cache u_pde_cache (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush | fault_now),
    .wr     (acked & state == PDE_RD & mem_rdata[P]),
    .tag    (walk_linear[31:22]),
    .wr_pde (mem_rdata | A_MASK),
    .hit    (hit),
    .pde    (cached_pde)
  );
`else
  assign hit = 1'b0;
  assign cached_pde = '0;
`endif
  // A flush landing in the FILL cycle itself must still suppress the fill, so gate with the live flush.
  assign tlbregs_write_do = state == FILL && !(stale || flush);
  assign walk_retry = state == FILL && (stale || flush);
  assign tlbregs_write_linear = lin;
  assign tlbregs_write_physical = {pte[31:12], 12'h000};
  assign tlbregs_write_pwt = pte[PWT];
  assign tlbregs_write_pcd = pte[PCD];
  assign tlbregs_write_combined_rw = pde[RW] & pte[RW];
  assign tlbregs_write_combined_su = pde[US] & pte[US];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      stale           <= 1'b0;
      pde             <= '0;
      pte             <= '0;
      lin             <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      walk_done       <= 1'b0;
      walk_fault      <= 1'b0;
      walk_fault_code <= 3'b000;
    end else begin
      walk_done       <= 1'b0;
      walk_fault      <= 1'b0;
      walk_fault_code <= 3'b000;
      if (state != IDLE && flush) stale <= 1'b1;
      case (state)
        IDLE: if (walk_req && !walk_done) begin
          stale <= 1'b0;
          lin   <= walk_linear;
          pde   <= cached_pde;
          state <= hit ? PTE_RD : PDE_RD;
        end
        PDE_RD: if (!mem_req) begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= entry_addr(cr3[31:12], lin[31:22]);
        end else if (mem_ack) begin
          mem_req <= 1'b0;
          pde     <= mem_rdata;
          if (!mem_rdata[P]) begin
            state           <= FAULT;
            walk_done       <= 1'b1;
            walk_fault      <= 1'b1;
            walk_fault_code <= fault_code(walk_su, walk_rw, 1'b0);
          end else begin
            state <= WB_AD && !mem_rdata[A] ? PDE_WB : PTE_RD;
          end
        end
        PDE_WB: if (!mem_req) begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= entry_addr(cr3[31:12], lin[31:22]);
          mem_wdata <= pde | A_MASK;
        end else if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          pde     <= pde | A_MASK;
          state   <= PTE_RD;
        end
        PTE_RD: if (!mem_req) begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= entry_addr(pde[31:12], lin[21:12]);
        end else if (mem_ack) begin
          mem_req <= 1'b0;
          pte     <= mem_rdata;
          if (!mem_rdata[P] || perm_fail(pde, mem_rdata, walk_rw, walk_su, cr0_wp)) begin
            state           <= FAULT;
            walk_done       <= 1'b1;
            walk_fault      <= 1'b1;
            walk_fault_code <= fault_code(walk_su, walk_rw, mem_rdata[P]);
          end else if (WB_AD && (!mem_rdata[A] || (walk_rw && !mem_rdata[D]))) begin
            state <= PTE_WB;
          end else begin
            state     <= FILL;
            walk_done <= 1'b1;
          end
        end
        PTE_WB: if (!mem_req) begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= entry_addr(pde[31:12], lin[21:12]);
          mem_wdata <= pte | A_MASK | (walk_rw ? D_MASK : 32'h0);
        end else if (mem_ack) begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          pte       <= mem_wdata;
          state     <= FILL;
          walk_done <= 1'b1;
        end
        FILL:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
